// File: rtl/ctr_word_dec_pkg.sv
// Shared definitions for the block-matching control interface: opcodes,
// FSM encoding and geometry defaults agreed between control unit and decoder.
package ctr_word_dec_pkg;

    localparam int DEF_BLK_SIZE = 16;
    localparam int DEF_SW_SIZE  = 31;

    localparam logic [3:0] OP_NOP      = 4'h0;
    localparam logic [3:0] OP_RST_PTR  = 4'h1;
    localparam logic [3:0] OP_STEP_COL = 4'h2;
    localparam logic [3:0] OP_STEP_ROW = 4'h3;
    localparam logic [3:0] OP_BANK_UP  = 4'h4;
    localparam logic [3:0] OP_BANK_LO  = 4'h5;
    localparam logic [3:0] OP_SHIFT    = 4'h6;
    localparam logic [3:0] OP_LATCH    = 4'h7;
    localparam logic [3:0] OP_RSVD_MIN = 4'h8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_READY = 2'd2,
        ST_SCAN  = 2'd3
    } state_t;

endpackage

// File: rtl/sw_addr_gen.sv
// Row/column walker over the search window; emits the registered linear
// read address and a one-cycle pulse when the row counter wraps.
module sw_addr_gen #(
    parameter int SW_SIZE = 31,
    parameter int SW_AW   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             step_col,
    input  logic             step_row,
    output logic [SW_AW-1:0] addr,
    output logic             wrap
);

    localparam int RC_W = $clog2(SW_SIZE);
    localparam logic [RC_W-1:0] LAST = RC_W'(SW_SIZE - 1);

    logic [RC_W-1:0]  row_q, row_d;
    logic [RC_W-1:0]  col_q, col_d;
    logic [SW_AW-1:0] addr_q, addr_d;
    logic             wrap_q, wrap_d;

    always_comb begin
        row_d  = row_q;
        col_d  = col_q;
        wrap_d = 1'b0;
        if (clear) begin
            row_d = '0;
            col_d = '0;
        end else if (step_col || step_row) begin
            // A row step, or a column step off the last column, advances the row.
            if (step_row || col_q == LAST) begin
                col_d = '0;
                if (row_q == LAST) begin
                    row_d  = '0;
                    wrap_d = 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        addr_d = SW_AW'(row_d) * SW_AW'(SW_SIZE) + SW_AW'(col_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_q  <= '0;
            col_q  <= '0;
            addr_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            row_q  <= row_d;
            col_q  <= col_d;
            addr_q <= addr_d;
            wrap_q <= wrap_d;
        end
    end

    assign addr = addr_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/ctr_word_dec.sv
// Control-word decoder: loads the reference block, then turns SCAN opcodes
// into registered search-window read and PE-array strobes (latency 1).
module ctr_word_dec
    import ctr_word_dec_pkg::*;
#(
    parameter int WORD_WIDETH = 8,
    parameter int BLK_SIZE    = DEF_BLK_SIZE,
    parameter int SW_SIZE     = DEF_SW_SIZE,
    parameter int REF_AW      = 8,
    parameter int SW_AW       = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [3:0]             ctr_word,
    input  logic                   mem_en_input,
    input  logic                   mem_init_mode,
    input  logic [WORD_WIDETH-1:0] pix_in,
    input  logic                   pix_valid,
    output logic                   ref_wr_en,
    output logic [REF_AW-1:0]      ref_wr_addr,
    output logic [WORD_WIDETH-1:0] ref_wr_data,
    output logic                   sw_rd_en,
    output logic [SW_AW-1:0]       sw_rd_addr,
    output logic                   bank_sel,
    output logic                   pe_shift,
    output logic                   sad_latch,
    output logic                   scan_wrap,
    output logic                   ref_loaded,
    output logic                   err_opcode,
    output state_t                 dbg_state
);

    localparam logic [REF_AW-1:0] LAST_PIX = REF_AW'(BLK_SIZE * BLK_SIZE - 1);

    state_t                 state_q, state_d;
    logic [REF_AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic                   ref_wr_en_q, ref_wr_en_d;
    logic [REF_AW-1:0]      ref_wr_addr_q, ref_wr_addr_d;
    logic [WORD_WIDETH-1:0] ref_wr_data_q, ref_wr_data_d;
    logic                   ref_loaded_q, ref_loaded_d;
    logic                   sw_rd_en_q, sw_rd_en_d;
    logic                   bank_sel_q, bank_sel_d;
    logic                   pe_shift_q, pe_shift_d;
    logic                   sad_latch_q, sad_latch_d;
    logic                   err_q, err_d;
    logic                   clear, step_col, step_row;

    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        ref_wr_en_d   = 1'b0;
        ref_wr_addr_d = ref_wr_addr_q;
        ref_wr_data_d = ref_wr_data_q;
        ref_loaded_d  = ref_loaded_q;
        sw_rd_en_d    = 1'b0;
        bank_sel_d    = bank_sel_q;
        pe_shift_d    = 1'b0;
        sad_latch_d   = 1'b0;
        err_d         = err_q;
        clear         = 1'b0;
        step_col      = 1'b0;
        step_row      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_en_input && mem_init_mode) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                end
            end
            ST_LOAD: begin
                if (!mem_en_input || !mem_init_mode) begin
                    state_d = ST_IDLE;
                end else if (pix_valid) begin
                    ref_wr_en_d   = 1'b1;
                    ref_wr_addr_d = wr_ptr_q;
                    ref_wr_data_d = pix_in;
                    wr_ptr_d      = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST_PIX) begin
                        state_d      = ST_READY;
                        ref_loaded_d = 1'b1;
                    end
                end
            end
            ST_READY: begin
                if (mem_en_input) begin
                    if (mem_init_mode) begin
                        state_d      = ST_LOAD;
                        ref_loaded_d = 1'b0;
                        wr_ptr_d     = '0;
                    end else begin
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (!mem_en_input) begin
                    state_d = ST_READY;
                end else if (mem_init_mode) begin
                    state_d      = ST_LOAD;
                    ref_loaded_d = 1'b0;
                    wr_ptr_d     = '0;
                end else begin
                    case (ctr_word)
                        OP_NOP:      ;
                        OP_RST_PTR:  begin clear    = 1'b1; sw_rd_en_d = 1'b1; end
                        OP_STEP_COL: begin step_col = 1'b1; sw_rd_en_d = 1'b1; end
                        OP_STEP_ROW: begin step_row = 1'b1; sw_rd_en_d = 1'b1; end
                        OP_BANK_UP:  bank_sel_d  = 1'b0;
                        OP_BANK_LO:  bank_sel_d  = 1'b1;
                        OP_SHIFT:    pe_shift_d  = 1'b1;
                        OP_LATCH:    sad_latch_d = 1'b1;
                        default:     err_d       = 1'b1;  // OP_RSVD_MIN and above
                    endcase
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            ref_wr_en_q   <= 1'b0;
            ref_wr_addr_q <= '0;
            ref_wr_data_q <= '0;
            ref_loaded_q  <= 1'b0;
            sw_rd_en_q    <= 1'b0;
            bank_sel_q    <= 1'b0;
            pe_shift_q    <= 1'b0;
            sad_latch_q   <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            ref_wr_en_q   <= ref_wr_en_d;
            ref_wr_addr_q <= ref_wr_addr_d;
            ref_wr_data_q <= ref_wr_data_d;
            ref_loaded_q  <= ref_loaded_d;
            sw_rd_en_q    <= sw_rd_en_d;
            bank_sel_q    <= bank_sel_d;
            pe_shift_q    <= pe_shift_d;
            sad_latch_q   <= sad_latch_d;
            err_q         <= err_d;
        end
    end

    sw_addr_gen #(
        .SW_SIZE (SW_SIZE),
        .SW_AW   (SW_AW)
    ) u_sw_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .step_col (step_col),
        .step_row (step_row),
        .addr     (sw_rd_addr),
        .wrap     (scan_wrap)
    );

    assign ref_wr_en   = ref_wr_en_q;
    assign ref_wr_addr = ref_wr_addr_q;
    assign ref_wr_data = ref_wr_data_q;
    assign ref_loaded  = ref_loaded_q;
    assign sw_rd_en    = sw_rd_en_q;
    assign bank_sel    = bank_sel_q;
    assign pe_shift    = pe_shift_q;
    assign sad_latch   = sad_latch_q;
    assign err_opcode  = err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_ctr_word_dec.sv
// Directed bench for ctr_word_dec: reference load, abort, scan walk, wrap,
// opcode pulses and synchronous reset during a scan.
module tb_ctr_word_dec;
    import ctr_word_dec_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [3:0] ctr_word;
    logic       mem_en_input;
    logic       mem_init_mode;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       ref_wr_en;
    logic [7:0] ref_wr_addr;
    logic [7:0] ref_wr_data;
    logic       sw_rd_en;
    logic [9:0] sw_rd_addr;
    logic       bank_sel;
    logic       pe_shift;
    logic       sad_latch;
    logic       scan_wrap;
    logic       ref_loaded;
    logic       err_opcode;
    state_t     dbg_state;

    int tests = 0;
    int fails = 0;

    logic [33:0] all_out;
    assign all_out = {ref_wr_en, ref_wr_addr, ref_wr_data, sw_rd_en, sw_rd_addr,
                      bank_sel, pe_shift, sad_latch, scan_wrap, ref_loaded, err_opcode};

    ctr_word_dec dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ctr_word      (ctr_word),
        .mem_en_input  (mem_en_input),
        .mem_init_mode (mem_init_mode),
        .pix_in        (pix_in),
        .pix_valid     (pix_valid),
        .ref_wr_en     (ref_wr_en),
        .ref_wr_addr   (ref_wr_addr),
        .ref_wr_data   (ref_wr_data),
        .sw_rd_en      (sw_rd_en),
        .sw_rd_addr    (sw_rd_addr),
        .bank_sel      (bank_sel),
        .pe_shift      (pe_shift),
        .sad_latch     (sad_latch),
        .scan_wrap     (scan_wrap),
        .ref_loaded    (ref_loaded),
        .err_opcode    (err_opcode),
        .dbg_state     (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_full();
        mem_en_input = 1'b1; mem_init_mode = 1'b1; pix_valid = 1'b0;
        step();
        for (int i = 0; i < 256; i++) begin
            pix_in = i[7:0]; pix_valid = 1'b1;
            step();
        end
        mem_en_input = 1'b0; mem_init_mode = 1'b0; pix_valid = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ctr_word = OP_NOP; mem_en_input = 1'b0; mem_init_mode = 1'b0;
        pix_in = '0; pix_valid = 1'b0;
        step(); step();
        tests++;
        if (all_out !== 34'd0 || dbg_state !== ST_IDLE) begin
            fails++;
            $display("FAIL reset: outputs=%h state=%0d, required 0 / IDLE", all_out, dbg_state);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load();
        mem_en_input = 1'b1; mem_init_mode = 1'b1; pix_valid = 1'b0;
        step();
        tests++;
        if (dbg_state !== ST_LOAD || ref_wr_en !== 1'b0) begin
            fails++;
            $display("FAIL load_enter: state=%0d wr_en=%b, required LOAD / 0", dbg_state, ref_wr_en);
        end
        for (int i = 0; i < 256; i++) begin
            pix_in = i[7:0]; pix_valid = 1'b1;
            if (i == 255) begin mem_en_input = 1'b0; end
            else begin mem_en_input = 1'b1; end
            // Drop enable on the last beat? No: keep it high for the final write.
            mem_en_input = 1'b1;
            step();
            tests++;
            if (ref_wr_en !== 1'b1 || ref_wr_addr !== i[7:0] || ref_wr_data !== i[7:0] ||
                ref_loaded !== (i == 255) || dbg_state !== ((i == 255) ? ST_READY : ST_LOAD)) begin
                fails++;
                $display("FAIL load_beat %0d: en=%b addr=%0d data=%0d loaded=%b state=%0d", i,
                         ref_wr_en, ref_wr_addr, ref_wr_data, ref_loaded, dbg_state);
            end
        end
        mem_en_input = 1'b0; mem_init_mode = 1'b0; pix_valid = 1'b0;
        step();
        tests++;
        if (ref_wr_en !== 1'b0 || ref_loaded !== 1'b1 || dbg_state !== ST_READY) begin
            fails++;
            $display("FAIL load_done: en=%b loaded=%b state=%0d, required 0/1/READY",
                     ref_wr_en, ref_loaded, dbg_state);
        end
    endtask

    task automatic test_abort();
        int writes;
        writes = 0;
        mem_en_input = 1'b1; mem_init_mode = 1'b1; pix_valid = 1'b0;
        step();
        tests++;
        if (dbg_state !== ST_LOAD || ref_loaded !== 1'b0) begin
            fails++;
            $display("FAIL reload_enter: state=%0d loaded=%b, required LOAD / 0", dbg_state, ref_loaded);
        end
        for (int i = 0; i < 100; i++) begin
            pix_in = 8'(i + 7); pix_valid = 1'b1;
            step();
            if (ref_wr_en === 1'b1) writes++;
        end
        mem_init_mode = 1'b0; pix_in = 8'hEE; pix_valid = 1'b1;
        step();
        if (ref_wr_en === 1'b1) writes++;
        tests++;
        if (writes != 100 || ref_loaded !== 1'b0 || dbg_state !== ST_IDLE) begin
            fails++;
            $display("FAIL abort: writes=%0d loaded=%b state=%0d, required 100/0/IDLE",
                     writes, ref_loaded, dbg_state);
        end
        mem_en_input = 1'b0; pix_valid = 1'b0;
        step();
        mem_en_input = 1'b1; mem_init_mode = 1'b1;
        step();
        pix_in = 8'h5A; pix_valid = 1'b1;
        step();
        tests++;
        if (ref_wr_en !== 1'b1 || ref_wr_addr !== 8'd0 || ref_wr_data !== 8'h5A) begin
            fails++;
            $display("FAIL restart_addr: en=%b addr=%0d data=%h, required 1/0/5a",
                     ref_wr_en, ref_wr_addr, ref_wr_data);
        end
        for (int i = 1; i < 256; i++) begin
            pix_in = i[7:0];
            step();
        end
        mem_en_input = 1'b0; mem_init_mode = 1'b0; pix_valid = 1'b0;
        step();
        tests++;
        if (dbg_state !== ST_READY || ref_loaded !== 1'b1 || ref_wr_addr !== 8'd255) begin
            fails++;
            $display("FAIL restart_done: state=%0d loaded=%b addr=%0d, required READY/1/255",
                     dbg_state, ref_loaded, ref_wr_addr);
        end
    endtask

    task automatic test_scan_cols();
        mem_en_input = 1'b1; mem_init_mode = 1'b0; ctr_word = OP_NOP;
        step();
        tests++;
        if (dbg_state !== ST_SCAN || sw_rd_en !== 1'b0) begin
            fails++;
            $display("FAIL scan_enter: state=%0d rd_en=%b, required SCAN / 0", dbg_state, sw_rd_en);
        end
        ctr_word = OP_RST_PTR;
        step();
        tests++;
        if (sw_rd_en !== 1'b1 || sw_rd_addr !== 10'd0) begin
            fails++;
            $display("FAIL rst_ptr: rd_en=%b addr=%0d, required 1 / 0", sw_rd_en, sw_rd_addr);
        end
        for (int k = 1; k <= 31; k++) begin
            ctr_word = OP_STEP_COL;
            step();
            tests++;
            if (sw_rd_en !== 1'b1 || sw_rd_addr !== 10'(k) || scan_wrap !== 1'b0) begin
                fails++;
                $display("FAIL step_col %0d: rd_en=%b addr=%0d wrap=%b, required 1/%0d/0",
                         k, sw_rd_en, sw_rd_addr, scan_wrap, k);
            end
        end
        ctr_word = OP_NOP;
        step();
        tests++;
        if (sw_rd_en !== 1'b0 || sw_rd_addr !== 10'd31) begin
            fails++;
            $display("FAIL nop_hold: rd_en=%b addr=%0d, required 0 / 31", sw_rd_en, sw_rd_addr);
        end
    endtask

    task automatic test_wrap();
        int wraps;
        wraps = 0;
        ctr_word = OP_RST_PTR;
        step();
        for (int k = 0; k < 960; k++) begin
            ctr_word = OP_STEP_COL;
            step();
            if (scan_wrap !== 1'b0) wraps++;
        end
        tests++;
        if (sw_rd_addr !== 10'd960 || wraps != 0) begin
            fails++;
            $display("FAIL walk_end: addr=%0d early_wraps=%0d, required 960 / 0", sw_rd_addr, wraps);
        end
        step();
        tests++;
        if (sw_rd_addr !== 10'd0 || scan_wrap !== 1'b1 || sw_rd_en !== 1'b1) begin
            fails++;
            $display("FAIL col_wrap: addr=%0d wrap=%b rd_en=%b, required 0/1/1",
                     sw_rd_addr, scan_wrap, sw_rd_en);
        end
        ctr_word = OP_NOP;
        step();
        tests++;
        if (scan_wrap !== 1'b0 || sw_rd_addr !== 10'd0) begin
            fails++;
            $display("FAIL wrap_pulse: wrap=%b addr=%0d, required 0 / 0", scan_wrap, sw_rd_addr);
        end
    endtask

    task automatic test_step_row();
        int wraps;
        wraps = 0;
        ctr_word = OP_RST_PTR;
        step();
        ctr_word = OP_STEP_COL;
        step(); step(); step();
        ctr_word = OP_STEP_ROW;
        step();
        tests++;
        if (sw_rd_addr !== 10'd31 || sw_rd_en !== 1'b1) begin
            fails++;
            $display("FAIL step_row: addr=%0d rd_en=%b, required 31 / 1", sw_rd_addr, sw_rd_en);
        end
        for (int k = 0; k < 29; k++) begin
            step();
            if (scan_wrap !== 1'b0) wraps++;
        end
        tests++;
        if (sw_rd_addr !== 10'd930 || wraps != 0) begin
            fails++;
            $display("FAIL row_last: addr=%0d early_wraps=%0d, required 930 / 0", sw_rd_addr, wraps);
        end
        step();
        tests++;
        if (sw_rd_addr !== 10'd0 || scan_wrap !== 1'b1) begin
            fails++;
            $display("FAIL row_wrap: addr=%0d wrap=%b, required 0 / 1", sw_rd_addr, scan_wrap);
        end
    endtask

    task automatic test_opcodes();
        ctr_word = OP_SHIFT;
        step();
        tests++;
        if (pe_shift !== 1'b1 || sad_latch !== 1'b0 || sw_rd_en !== 1'b0) begin
            fails++;
            $display("FAIL shift: shift=%b latch=%b rd_en=%b, required 1/0/0", pe_shift, sad_latch, sw_rd_en);
        end
        ctr_word = OP_LATCH;
        step();
        tests++;
        if (pe_shift !== 1'b0 || sad_latch !== 1'b1) begin
            fails++;
            $display("FAIL latch: shift=%b latch=%b, required 0/1", pe_shift, sad_latch);
        end
        ctr_word = OP_BANK_LO;
        step();
        tests++;
        if (bank_sel !== 1'b1 || sad_latch !== 1'b0 || sw_rd_en !== 1'b0) begin
            fails++;
            $display("FAIL bank_lo: bank=%b latch=%b rd_en=%b, required 1/0/0", bank_sel, sad_latch, sw_rd_en);
        end
        ctr_word = 4'h9;
        step();
        tests++;
        if (err_opcode !== 1'b1 || bank_sel !== 1'b1 || sw_rd_en !== 1'b0) begin
            fails++;
            $display("FAIL rsvd: err=%b bank=%b rd_en=%b, required 1/1/0", err_opcode, bank_sel, sw_rd_en);
        end
        ctr_word = OP_NOP;
        step();
        tests++;
        if (err_opcode !== 1'b1 || bank_sel !== 1'b1 || ref_loaded !== 1'b1) begin
            fails++;
            $display("FAIL sticky: err=%b bank=%b loaded=%b, required 1/1/1", err_opcode, bank_sel, ref_loaded);
        end
        ctr_word = OP_BANK_UP;
        step();
        tests++;
        if (bank_sel !== 1'b0) begin
            fails++;
            $display("FAIL bank_up: bank=%b, required 0", bank_sel);
        end
        ctr_word = OP_BANK_LO; mem_en_input = 1'b0;
        step();
        tests++;
        if (dbg_state !== ST_READY || bank_sel !== 1'b0 || err_opcode !== 1'b1) begin
            fails++;
            $display("FAIL scan_exit: state=%0d bank=%b err=%b, required READY/0/1",
                     dbg_state, bank_sel, err_opcode);
        end
    endtask

    task automatic test_reset_mid_scan();
        mem_en_input = 1'b1; mem_init_mode = 1'b0; ctr_word = OP_NOP;
        step();
        ctr_word = OP_RST_PTR;
        step();
        ctr_word = OP_STEP_ROW;
        for (int k = 0; k < 3; k++) step();
        ctr_word = OP_STEP_COL;
        for (int k = 0; k < 7; k++) step();
        tests++;
        if (sw_rd_addr !== 10'd100) begin
            fails++;
            $display("FAIL pre_reset_addr: addr=%0d, required 100", sw_rd_addr);
        end
        rst_n = 1'b0; ctr_word = OP_SHIFT;
        step();
        tests++;
        if (all_out !== 34'd0 || dbg_state !== ST_IDLE) begin
            fails++;
            $display("FAIL mid_scan_reset: outputs=%h state=%0d, required 0 / IDLE", all_out, dbg_state);
        end
        rst_n = 1'b1; mem_en_input = 1'b0; ctr_word = OP_NOP;
        step();
    endtask

    task automatic test_scan_reload();
        load_full();
        mem_en_input = 1'b1; mem_init_mode = 1'b0; ctr_word = OP_NOP;
        step();
        mem_init_mode = 1'b1; ctr_word = OP_SHIFT; pix_in = 8'h33; pix_valid = 1'b1;
        step();
        tests++;
        if (dbg_state !== ST_LOAD || pe_shift !== 1'b0 || ref_wr_en !== 1'b0 || ref_loaded !== 1'b0) begin
            fails++;
            $display("FAIL scan_reload: state=%0d shift=%b wr_en=%b loaded=%b, required LOAD/0/0/0",
                     dbg_state, pe_shift, ref_wr_en, ref_loaded);
        end
        step();
        tests++;
        if (ref_wr_en !== 1'b1 || ref_wr_addr !== 8'd0 || ref_wr_data !== 8'h33) begin
            fails++;
            $display("FAIL reload_first: en=%b addr=%0d data=%h, required 1/0/33",
                     ref_wr_en, ref_wr_addr, ref_wr_data);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_abort();
        test_scan_cols();
        test_wrap();
        test_step_row();
        test_opcodes();
        test_reset_mid_scan();
        test_scan_reload();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
